// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit feeding the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Signed ops are handled by sign-fixing the result after the loop.
// Busy for 35 cycles per op: PREP, 32 x RUN, FIX, then WB.
//
// Ports
//   clk_i, rst_i     : core clock, synchronous active-high reset
//   start_i          : request, sampled only in IDLE
//   op_i             : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a_i, b_i         : rs / rt operands, latched when start is accepted
//   hilo_req_i       : decode holds an MFHI/MFLO/MTHI/MTLO
//   busy_o           : unit not in IDLE
//   stall_o          : hold the core (busy and a dependent request)
//   hilo_we_o        : one-cycle HI/LO write strobe
//   hi_out_o/lo_out_o: result words, zero outside the write cycle
//   div_by_zero_o    : pulses with hilo_we_o for DIV/DIVU with b=0
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hilo_req_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_out_o,
    output logic [WIDTH-1:0] lo_out_o,
    output logic             div_by_zero_o
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_WB} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   araw_q, araw_d;   // a as latched, needed for the b=0 result
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] acc_q, acc_d;     // {HI, LO} working register
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_lo_q, neg_lo_d; // product / quotient sign
    logic               neg_hi_q, neg_hi_d; // remainder sign
    logic               dz_q, dz_d;

    logic               sgn;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     upper;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        araw_d   = araw_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;

        sgn    = op_q[0];
        abs_a  = (sgn && araw_q[WIDTH-1]) ? -araw_q : araw_q;
        abs_b  = (sgn && b_q[WIDTH-1])    ? -b_q    : b_q;
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        // Divide: partial remainder shifted left with the next dividend bit.
        upper  = acc_q[2*WIDTH-1:WIDTH-1];
        ge     = (upper >= {1'b0, opnd_q});
        // Remainder after a successful trial subtract always fits WIDTH bits.
        diff   = upper[WIDTH-1:0] - opnd_q;
        hi_fix = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        lo_fix = neg_lo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    araw_d  = a_i;
                    b_d     = b_i;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                neg_lo_d = sgn & (araw_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_hi_d = sgn & araw_q[WIDTH-1];
                dz_d     = op_q[1] & (b_q == '0);
                // Multiplier (mul) or dividend (div) starts in LO, HI clear.
                acc_d    = {{WIDTH{1'b0}}, (op_q[1] ? abs_a : abs_b)};
                opnd_d   = op_q[1] ? abs_b : abs_a;
                cnt_d    = CW'(ITER - 1);
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (!op_q[1]) begin
                    if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
                    else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end else begin
                    if (ge) acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
                    else    acc_d = {upper[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                if (dz_q)              acc_d = {araw_q, {WIDTH{1'b1}}};
                else if (!op_q[1])     acc_d = neg_lo_q ? -acc_q : acc_q;
                else                   acc_d = {hi_fix, lo_fix};
                state_d = S_WB;
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            araw_q   <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            araw_q   <= araw_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    // No bypass: a HI/LO access during the WB cycle is held as well.
    assign stall_o       = busy_o & (hilo_req_i | start_i);
    assign hilo_we_o     = (state_q == S_WB);
    assign hi_out_o      = hilo_we_o ? acc_q[2*WIDTH-1:WIDTH] : '0;
    assign lo_out_o      = hilo_we_o ? acc_q[WIDTH-1:0]       : '0;
    assign div_by_zero_o = hilo_we_o & dz_q;
endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst, start, hilo_req;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, stall, hilo_we, div_by_zero;
    logic [31:0] hi_out, lo_out;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .hilo_req_i(hilo_req), .busy_o(busy), .stall_o(stall), .hilo_we_o(hilo_we),
        .hi_out_o(hi_out), .lo_out_o(lo_out), .div_by_zero_o(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r, p;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: res = {32'b0, x} * {32'b0, y};
            2'b01: begin p = sx * sy; res = p; end
            2'b10: res = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            default: begin
                if (y == 0) res = {x, 32'hFFFFFFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Issue one op; expected result written 34 negedges after the accepting edge,
    // busy for 35 cycles. With intf set, extra start/hilo_req pulses hit the busy window.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit intf);
        logic [63:0] e;
        int lat, nbusy, nwe;
        logic [31:0] hi_s, lo_s;
        logic dz_s;
        bit poke;
        lat = -1; nbusy = 0; nwe = 0; hi_s = '0; lo_s = '0; dz_s = 1'b0;
        e = ref_model(o, x, y);
        @(negedge clk);
        start = 1'b1; hilo_req = 1'b0; op = o; a = x; b = y;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0; hilo_req = 1'b0;
            a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
            poke = intf && (k >= 2) && (k <= 34) && (k % 3 == 0);
            if (poke) begin start = 1'b1; hilo_req = 1'b1; end
            #1;
            if (poke) chk("stall_busy", stall, 1);
            else      chk("stall_noreq", stall, 0);
            if (busy) nbusy++;
            if (hilo_we) begin
                nwe++; lat = k; hi_s = hi_out; lo_s = lo_out; dz_s = div_by_zero;
            end
        end
        start = 1'b0; hilo_req = 1'b1;
        #1 chk("stall_idle", stall, 0);
        hilo_req = 1'b0;
        chk("latency", lat, 34);
        chk("busy_cycles", nbusy, 35);
        chk("we_count", nwe, 1);
        chk("hi", hi_s, e[63:32]);
        chk("lo", lo_s, e[31:0]);
        chk("dz", dz_s, (o[1] && y == 0));
    endtask

    task automatic reset_mid_run();
        int nwe;
        nwe = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'hDEADBEEF; b = 32'h12345678;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_we", hilo_we, 0);
        chk("rst_hi", hi_out, 0);
        chk("rst_lo", lo_out, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1 if (hilo_we) nwe++;
        end
        chk("rst_no_we", nwe, 0);
        run_op(2'b00, 32'd2, 32'd3, 1'b0);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] x, y;
        rst = 1'b1; start = 1'b1; hilo_req = 1'b1; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_stall", stall, 0);
        chk("reset_we", hilo_we, 0);
        chk("reset_hi", hi_out, 0);
        chk("reset_lo", lo_out, 0);
        chk("reset_dz", div_by_zero, 0);
        start = 1'b0; hilo_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(2'b01, 32'hFFFFFFFD, 32'd5, 1'b0);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'd7, 32'd2, 1'b0);
        run_op(2'b10, 32'h00001234, 32'd0, 1'b0);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(2'b11, 32'hFFFF0000, 32'd0, 1'b0);
        run_op(2'b00, 32'h00001234, 32'h00005678, 1'b1);
        reset_mid_run();

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'd1;
                2: y = 32'hFFFFFFFF;
                3: y = 32'($urandom_range(1, 100));
                default: y = $urandom;
            endcase
            run_op(o, x, y, bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
